// File: rtl/cla_adder_2bit.sv
// Registered carry-lookahead adder slice with group propagate/generate outputs.
// Slices are chained through cout/cin to build wider adders.
module cla_adder_2bit #(
  parameter int WIDTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic             cin_last,
  output logic             grp_p,
  output logic             grp_g
);

  logic [WIDTH-1:0] p;
  logic [WIDTH-1:0] g;
  logic [WIDTH:0]   c;
  logic             term;
  logic             genOnly;
  logic             grpGen;

  assign p = a ^ b;
  assign g = a & b;

  // Each carry is a flat sum of products over g, p and cin (no ripple chain).
  // The generate-only part of the top carry doubles as the group generate.
  always_comb begin
    c       = '0;
    term    = 1'b0;
    genOnly = 1'b0;
    grpGen  = 1'b0;
    c[0]    = cin;
    for (int i = 0; i < WIDTH; i++) begin
      genOnly = 1'b0;
      for (int j = 0; j <= i; j++) begin
        term = g[j];
        for (int k = j + 1; k <= i; k++) begin
          term = term & p[k];
        end
        genOnly = genOnly | term;
      end
      term = cin;
      for (int k = 0; k <= i; k++) begin
        term = term & p[k];
      end
      c[i+1] = genOnly | term;
      if (i == WIDTH - 1) begin
        grpGen = genOnly;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s        <= '0;
      cout     <= 1'b0;
      cin_last <= 1'b0;
      grp_p    <= 1'b0;
      grp_g    <= 1'b0;
    end else begin
      s        <= p ^ c[WIDTH-1:0];
      cout     <= c[WIDTH];
      cin_last <= c[WIDTH-1];
      grp_p    <= &p;
      grp_g    <= grpGen;
    end
  end

endmodule

// File: tb/tb_cla_adder_2bit.sv
// Scoreboard bench for cla_adder_2bit: single-slice vectors plus a
// four-slice 8-bit chain.
module tb_cla_adder_2bit;

  typedef struct {
    logic [1:0] s;
    logic       cout;
    logic       cinLast;
    logic       grpP;
    logic       grpG;
    logic       ovf;
  } result_t;

  typedef struct {
    logic [7:0] sum;
    logic       carry;
    logic       ovf;
  } chain_t;

  typedef struct {
    logic       rst;
    logic [1:0] a;
    logic [1:0] b;
    logic       cin;
    result_t    exp;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] a = '0;
  logic [1:0] b = '0;
  logic       cin = 1'b0;
  logic [1:0] s;
  logic       cout, cin_last, grp_p, grp_g;

  logic       inVld = 1'b0;
  logic       chainStrobe = 1'b0;
  logic [7:0] chA = '0;
  logic [7:0] chB = '0;
  logic [7:0] chSum;
  logic [3:0] chCout, chCl, chGp, chGg;
  logic [4:0] chC;

  result_t expQ[$];
  chain_t  chainQ[$];
  int      checks = 0;
  int      errors = 0;

  always #5 clk = ~clk;

  cla_adder_2bit #(.WIDTH(2)) dut (
    .clk(clk), .rst(rst), .a(a), .b(b), .cin(cin),
    .s(s), .cout(cout), .cin_last(cin_last), .grp_p(grp_p), .grp_g(grp_g)
  );

  // Four slices chained carry-to-carry; each hop adds one register stage.
  assign chC[0] = 1'b0;
  for (genvar k = 0; k < 4; k++) begin : gChain
    assign chC[k+1] = chCout[k];
    cla_adder_2bit #(.WIDTH(2)) slice (
      .clk(clk), .rst(rst), .a(chA[2*k+1:2*k]), .b(chB[2*k+1:2*k]), .cin(chC[k]),
      .s(chSum[2*k+1:2*k]), .cout(chCout[k]), .cin_last(chCl[k]),
      .grp_p(chGp[k]), .grp_g(chGg[k])
    );
  end

  task automatic checkOutput(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic r, input logic [1:0] va, input logic [1:0] vb,
                               input logic vc, input result_t exp);
    @(negedge clk);
    rst   = r;
    a     = va;
    b     = vb;
    cin   = vc;
    inVld = 1'b1;
    expQ.push_back(exp);
  endtask

  function automatic result_t model(input logic [1:0] va, input logic [1:0] vb, input logic vc);
    result_t    r;
    logic [2:0] full;
    logic [1:0] low;
    full      = {1'b0, va} + {1'b0, vb} + {2'b00, vc};
    low       = {1'b0, va[0]} + {1'b0, vb[0]} + {1'b0, vc};
    r.s       = full[1:0];
    r.cout    = full[2];
    r.cinLast = low[1];
    r.grpP    = &(va ^ vb);
    r.grpG    = (va[1] & vb[1]) | ((va[1] ^ vb[1]) & va[0] & vb[0]);
    r.ovf     = r.cout ^ r.cinLast;
    return r;
  endfunction

  // Monitor: a transaction issued before an edge is checked after that edge.
  initial begin
    logic gotVld, gotChain;
    result_t e;
    chain_t  ce;
    forever begin
      @(posedge clk);
      gotVld   = inVld;
      gotChain = chainStrobe;
      @(negedge clk);
      if (gotVld) begin
        if (expQ.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL scoreboard: got output with empty queue expected entry");
        end else begin
          e = expQ.pop_front();
          checkOutput("s", {6'b0, s}, {6'b0, e.s});
          checkOutput("cout", {7'b0, cout}, {7'b0, e.cout});
          checkOutput("cin_last", {7'b0, cin_last}, {7'b0, e.cinLast});
          checkOutput("grp_p", {7'b0, grp_p}, {7'b0, e.grpP});
          checkOutput("grp_g", {7'b0, grp_g}, {7'b0, e.grpG});
          checkOutput("ovf", {7'b0, cout ^ cin_last}, {7'b0, e.ovf});
        end
      end
      if (gotChain && chainQ.size() != 0) begin
        ce = chainQ.pop_front();
        checkOutput("chain_sum", chSum, ce.sum);
        checkOutput("chain_carry", {7'b0, chCout[3]}, {7'b0, ce.carry});
        checkOutput("chain_ovf", {7'b0, chCout[3] ^ chCl[3]}, {7'b0, ce.ovf});
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Hand-computed directed vectors: rst, a, b, cin -> s, cout, cin_last, grp_p, grp_g, ovf
  vec_t dirVecs[9] = '{
    '{1'b1, 2'b11, 2'b11, 1'b1, '{2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0}},
    '{1'b1, 2'b11, 2'b11, 1'b1, '{2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0}},
    '{1'b0, 2'b11, 2'b11, 1'b1, '{2'b11, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0}},
    '{1'b0, 2'b01, 2'b01, 1'b0, '{2'b10, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1}},
    '{1'b0, 2'b10, 2'b01, 1'b1, '{2'b00, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0}},
    '{1'b0, 2'b10, 2'b01, 1'b0, '{2'b11, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0}},
    '{1'b0, 2'b10, 2'b01, 1'b0, '{2'b11, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0}},
    '{1'b0, 2'b11, 2'b11, 1'b0, '{2'b10, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0}},
    '{1'b1, 2'b01, 2'b10, 1'b1, '{2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0}}
  };

  // 8-bit chain vectors: a, b -> sum, carry, ovf
  logic [7:0] chainA[3]   = '{8'hFF, 8'h7F, 8'h55};
  logic [7:0] chainB[3]   = '{8'h01, 8'h01, 8'hAA};
  chain_t     chainExp[3] = '{'{8'h00, 1'b1, 1'b0}, '{8'h80, 1'b0, 1'b1}, '{8'hFF, 1'b0, 1'b0}};

  initial begin
    int waitCycles;
    foreach (dirVecs[i])
      applyStimulus(dirVecs[i].rst, dirVecs[i].a, dirVecs[i].b, dirVecs[i].cin, dirVecs[i].exp);

    for (int ai = 0; ai < 4; ai++)
      for (int bi = 0; bi < 4; bi++)
        for (int ci = 0; ci < 2; ci++)
          applyStimulus(1'b0, 2'(ai), 2'(bi), 1'(ci), model(2'(ai), 2'(bi), 1'(ci)));

    @(negedge clk);
    inVld = 1'b0;

    foreach (chainA[i]) begin
      chA = chainA[i];
      chB = chainB[i];
      repeat (6) @(negedge clk);
      chainQ.push_back(chainExp[i]);
      chainStrobe = 1'b1;
      @(negedge clk);
      chainStrobe = 1'b0;
    end

    waitCycles = 0;
    while ((expQ.size() != 0 || chainQ.size() != 0) && waitCycles < 10) begin
      @(negedge clk);
      waitCycles++;
    end
    repeat (2) @(negedge clk);
    if (expQ.size() != 0 || chainQ.size() != 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL drain: %0d entries left expected 0", expQ.size() + chainQ.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
